// File: rtl/serial_addsub.sv
// Purpose : digit-serial two's-complement add/subtract, DIGIT bits per cycle through a ripple slice.
// Latency : out_valid rises WIDTH/DIGIT cycles after the accepting edge.
// Backpress: one operation in flight; in_ready low until the result is taken; result held while out_ready=0.
//
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   in_valid/in_ready, a, b, sub   - operand handshake (sub=1 computes a-b)
//   out_valid/out_ready, s, c_out, ovf - result handshake, carry out of MSB, signed overflow
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   rc;      // ripple carries through the slice; rc[DIGIT-1] feeds the slice MSB
    logic [WIDTH-1:0] r_nxt;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(N - 1));

    // DIGIT-bit ripple-carry slice over the low digit of the operand shifters
    always_comb begin
        rc    = '0;
        dsum  = '0;
        rc[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ rc[i];
            rc[i+1]  = (a_sh[i] & b_sh[i]) | (rc[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New digit enters at the top so after N shifts the first digit sits at bit 0
    always_comb begin
        r_nxt = (r_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // subtract as a + ~b + 1: the +1 rides in as the initial carry
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        r_sh  <= '0;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    r_sh  <= r_nxt;
                    carry <= rc[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s     <= r_nxt;
                        c_out <= rc[DIGIT];
                        ovf   <= rc[DIGIT] ^ rc[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0: DIGIT=4, 1: DIGIT=16, 2: DIGIT=1 (all WIDTH=16)
    logic        iv  [3];
    logic        ir  [3];
    logic        ov  [3];
    logic        orr [3];
    logic        subv[3];
    logic        co  [3];
    logic        of  [3];
    logic [15:0] av  [3];
    logic [15:0] bv  [3];
    logic [15:0] sv  [3];

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
        .sub(subv[0]), .out_valid(ov[0]), .out_ready(orr[0]), .s(sv[0]), .c_out(co[0]), .ovf(of[0]));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
        .sub(subv[1]), .out_valid(ov[1]), .out_ready(orr[1]), .s(sv[1]), .c_out(co[1]), .ovf(of[1]));
    serial_addsub #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
        .sub(subv[2]), .out_valid(ov[2]), .out_ready(orr[2]), .s(sv[2]), .c_out(co[2]), .ovf(of[2]));

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat_of[3] = '{4, 1, 16};

    // Independent reference: full-width sum, carry from bit 16, overflow from operand/result signs
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic sb_i);
        logic [15:0] yy;
        logic [16:0] t;
        exp_t        e;
        yy  = sb_i ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + {16'b0, sb_i};
        e.s = t[15:0];
        e.c = t[16];
        e.o = (x[15] == yy[15]) && (t[15] != x[15]);
        return e;
    endfunction

    task automatic accept(input int k, input logic [15:0] x, input logic [15:0] y, input logic sb_i,
                          input exp_t e, output logic ok);
        int w;
        @(negedge clk);
        iv[k] = 1'b1; av[k] = x; bv[k] = y; subv[k] = sb_i;
        w = 0;
        while (!ir[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = ir[k];
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout k=%0d in_ready=%0b required 1", k, ir[k]);
            iv[k] = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(e);
            #1;
            iv[k] = 1'b0;
            // scramble inputs: the DUT must have sampled them at the accept edge
            av[k] = 16'($urandom); bv[k] = 16'($urandom); subv[k] = 1'($urandom);
        end
    endtask

    task automatic wait_out(input int k, input int lat_exp, input string name);
        int  lat;
        logic got;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov[k]) got = 1'b1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_timeout out_valid never rose in %0d cycles", name, lat);
        end else if (lat != lat_exp) begin
            n_fail++;
            $display("FAIL %s_latency got %0d required %0d", name, lat, lat_exp);
        end
    endtask

    task automatic check_result(input int k, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s_scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            n_chk++;
            if (sv[k] !== e.s || co[k] !== e.c || of[k] !== e.o) begin
                n_fail++;
                $display("FAIL %s_result s=%h c=%b ovf=%b required s=%h c=%b ovf=%b",
                         name, sv[k], co[k], of[k], e.s, e.c, e.o);
            end
        end
    endtask

    task automatic handshake(input int k, input string name);
        @(negedge clk);
        orr[k] = 1'b1;
        @(posedge clk);
        #1;
        orr[k] = 1'b0;
        n_chk++;
        if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handshake out_valid=%b in_ready=%b required 0/1", name, ov[k], ir[k]);
        end
    endtask

    task automatic run_op(input int k, input logic [15:0] x, input logic [15:0] y, input logic sb_i,
                          input exp_t e, input string name);
        logic ok;
        accept(k, x, y, sb_i, e, ok);
        if (ok) begin
            wait_out(k, lat_of[k], name);
            if (ov[k]) check_result(k, name);
            else sb.delete();
            handshake(k, name);
        end
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || sv[k] !== 16'h0 || co[k] !== 1'b0 || of[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d ir=%b ov=%b s=%h c=%b o=%b required 1 0 0000 0 0",
                         k, ir[k], ov[k], sv[k], co[k], of[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op(0, 16'hFFF6, 16'd100, 1'b0, '{16'h005A, 1'b1, 1'b0}, "add_mixed");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, "pos_ovf");
        run_op(0, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, "neg_ovf_sub");
        run_op(0, 16'd5,    16'd7,    1'b1, '{16'hFFFE, 1'b0, 1'b0}, "sub_borrow");
        run_op(0, 16'hF376, 16'd15,   1'b0, '{16'hF385, 1'b0, 1'b0}, "add_neg");
    endtask

    task automatic test_backpressure();
        logic ok;
        exp_t e;
        accept(0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, ok);
        if (ok) begin
            wait_out(0, 4, "bp");
            e = sb[0];
            @(negedge clk);
            iv[0] = 1'b1; av[0] = 16'd1; bv[0] = 16'd1; subv[0] = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                n_chk++;
                if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sv[0] !== e.s || co[0] !== e.c || of[0] !== e.o) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc=%0d ov=%b ir=%b s=%h c=%b o=%b required 1 0 %h %b %b",
                             i, ov[0], ir[0], sv[0], co[0], of[0], e.s, e.c, e.o);
                end
            end
            check_result(0, "bp");
            // release with the competing request still asserted: it is accepted one edge later
            @(negedge clk);
            orr[0] = 1'b1;
            @(posedge clk);
            #1;
            orr[0] = 1'b0;
            n_chk++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_release ov=%b ir=%b required 0/1", ov[0], ir[0]);
            end
            sb.push_back('{16'h0002, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            iv[0] = 1'b0;
            wait_out(0, 4, "bp_next");
            check_result(0, "bp_next");
            handshake(0, "bp_next");
        end
    endtask

    task automatic test_reset_busy();
        logic ok;
        accept(0, 16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0}, ok);
        if (ok) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            sb.delete();
            #1;
            n_chk++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || sv[0] !== 16'h0 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_busy ov=%b ir=%b s=%h c=%b o=%b required 0 1 0000 0 0",
                         ov[0], ir[0], sv[0], co[0], of[0]);
            end
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                n_chk++;
                if (ov[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_abort cyc=%0d out_valid=%b required 0", i, ov[0]);
                end
            end
            run_op(0, 16'd63, 16'd127, 1'b0, '{16'd190, 1'b0, 1'b0}, "rst_fresh");
        end
    endtask

    task automatic test_sweep(input int k, input string name);
        logic [15:0] x, y;
        logic        sb_i;
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom); y = 16'($urandom); sb_i = 1'($urandom);
            if (i == 0) begin x = 16'h7FFF; y = 16'h7FFF; sb_i = 1'b0; end
            if (i == 1) begin x = 16'h8000; y = 16'h7FFF; sb_i = 1'b1; end
            if (i == 2) begin x = 16'h0000; y = 16'h0000; sb_i = 1'b1; end
            run_op(k, x, y, sb_i, model(x, y, sb_i), name);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; av[k] = '0; bv[k] = '0; subv[k] = 1'b0;
        end
        test_reset();
        test_add_sub();
        test_backpressure();
        test_reset_busy();
        test_sweep(1, "sweep_d16");
        test_sweep(2, "sweep_d1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, digit-serial two's-complement adder/subtractor and the parametrised successor to the fixed-width ripple-carry adder.
- Processes DIGIT bits per clock through a DIGIT-bit ripple-carry slice and a registered carry, so WIDTH and area/latency are set at instantiation.
- Adds an add/sub mode, signed-overflow detection and valid/ready handshakes on both sides.
- Sits between operand-producing logic and any result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly; DIGIT=WIDTH gives single-cycle compute.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- sub  input  1  0: s=a+b; 1: s=a-b.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (asynchronous, while rst=1): state=IDLE, in_ready=1, out_valid=0, s=0, c_out=0, ovf=0, internal shift registers, carry and digit counter cleared.
- Reset mid-operation aborts the operation; no out_valid is produced for it.
- FSM states: IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE; both are registered or derived purely from state.
- IDLE: on the edge with in_valid&in_ready:
  - latch A=a and B=(sub ? ~b : b);
  - set carry=sub;
  - set cnt=0;
  - go to BUSY.
  - a, b and sub are sampled only at this edge; later changes are ignored.
- BUSY: each edge:
  - add the low DIGIT bits of A and B plus carry;
  - shift the DIGIT result bits into the top of the result register, shifting A, B and the result right by DIGIT;
  - update carry.
  - On the edge completing digit N-1 (N=WIDTH/DIGIT), capture c_out=final carry, ovf=carry_into_MSB^final carry, s=full result, and go to DONE.
- Latency: out_valid rises exactly N cycles after the accepting edge (DIGIT=WIDTH gives 1 cycle).
- DONE: s, c_out and ovf are held stable while out_valid=1 and out_ready=0. On the edge with out_ready=1, go to IDLE; out_valid drops and in_ready rises on the same edge.
- in_valid asserted during BUSY/DONE is ignored (not accepted, not queued).
- Throughput: at most one operation per N+2 cycles (accept, N compute, handshake out).
- s, c_out and ovf keep their last result values in IDLE/BUSY until overwritten at completion.
- Arithmetic: all results are modulo 2^WIDTH, with no saturation. Subtraction uses the inverted-B-plus-one form, so c_out follows the standard carry (not borrow) convention.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Add, mixed signs: a=0xFFF6 (-10), b=100, sub=0 → s=0x005A, c_out=1, ovf=0, out_valid exactly 4 cycles after accept.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0 → s=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 → s=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1 → s=0xFFFE, c_out=0, ovf=0. Also a=-3210 (0xF376), b=15, sub=0 → s=0xF385, c_out=0, ovf=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → s/c_out/ovf stable, in_ready=0. A competing in_valid with a=1, b=1 is not accepted; the next accepted operation starts only after out_ready=1.
- Reset mid-BUSY: assert rst 2 cycles after accept → out_valid=0 immediately, in_ready=1, s=0. After release, a fresh a=63, b=127 add gives s=190 with latency 4.
- Config sweep: DIGIT=16 (latency 1) and DIGIT=1 (latency 16) with random a, b, sub → s, c_out and ovf match a reference model for 1000 operations.
